// File: rtl/sfx_player.sv
// sfx_player: sound-effect sequencer driven by game-core events.
//   Watches the eat / success / failure event levels, plays a short fixed
//   melody per event and drives a 1-bit square wave.
//   Priority: failure > success > eat. A higher-priority edge restarts playback;
//   equal or lower edges are dropped.
// Params: NOTE_LEN   cycles per note (>= 2)
//         TONE_SHIFT right shift applied to every half-period constant
// Ports:  clk, rst (sync, active-high)
//         i_eat, i_success, i_failure  event levels (rising edge triggers)
//         i_mute   forces o_audio low (only when SFX_MUTE_EN is defined)
//         o_audio  square-wave audio
//         o_busy   high while a melody is playing
// Build option: define SFX_MUTE_EN to add the i_mute port.
module sfx_player #(
  parameter int NOTE_LEN   = 2_097_152,
  parameter int TONE_SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_eat,
  input  logic i_success,
  input  logic i_failure,
`ifdef SFX_MUTE_EN
  input  logic i_mute,
`endif
  output logic o_audio,
  output logic o_busy
);

  // Shifted half-period, clamped so a tone never has a zero-length half cycle.
  function automatic int shf(input int base);
    int v;
    v = base >> TONE_SHIFT;
    return (v < 1) ? 1 : v;
  endfunction

  localparam int HP_C4 = shf(48112);
  localparam int HP_E4 = shf(38187);
  localparam int HP_G4 = shf(32111);
  localparam int HP_C5 = shf(24056);
  localparam int HP_E5 = shf(19093);
  localparam int HP_G5 = shf(16056);
  localparam int HP_C6 = shf(12028);

  // Tone counter only reaches HP-1, so clog2(HP) bits are enough.
  localparam int TW = (HP_C4 > 1) ? $clog2(HP_C4) : 1;
  localparam int DW = $clog2(NOTE_LEN);

  localparam logic [TW-1:0] M_C4 = TW'(HP_C4 - 1);
  localparam logic [TW-1:0] M_E4 = TW'(HP_E4 - 1);
  localparam logic [TW-1:0] M_G4 = TW'(HP_G4 - 1);
  localparam logic [TW-1:0] M_C5 = TW'(HP_C5 - 1);
  localparam logic [TW-1:0] M_E5 = TW'(HP_E5 - 1);
  localparam logic [TW-1:0] M_G5 = TW'(HP_G5 - 1);
  localparam logic [TW-1:0] M_C6 = TW'(HP_C6 - 1);
  localparam logic [DW-1:0] DUR_LAST = DW'(NOTE_LEN - 1);

  // Melody id doubles as its priority, so preemption is a plain compare.
  localparam logic [1:0] MEL_NONE = 2'd0;
  localparam logic [1:0] MEL_EAT  = 2'd1;
  localparam logic [1:0] MEL_SUC  = 2'd2;
  localparam logic [1:0] MEL_FAIL = 2'd3;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [2:0]    prev_q;
  logic [1:0]    mel_q, mel_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [TW-1:0] tone_q, tone_d;
  logic          phase_q, phase_d;

  logic [2:0]    edges;
  logic [1:0]    ev;
  logic [1:0]    last_idx;
  logic [TW-1:0] hp_m1;
  logic          start;

  assign edges = {i_failure, i_success, i_eat} & ~prev_q;

  always_comb begin
    ev = MEL_NONE;
    if (edges[2])      ev = MEL_FAIL;
    else if (edges[1]) ev = MEL_SUC;
    else if (edges[0]) ev = MEL_EAT;
  end

  // Note table: {melody, note index} -> half-period minus one.
  always_comb begin
    hp_m1 = M_C4;
    case ({mel_q, idx_q})
      4'b01_00: hp_m1 = M_E5;
      4'b01_01: hp_m1 = M_G5;
      4'b10_00: hp_m1 = M_C5;
      4'b10_01: hp_m1 = M_E5;
      4'b10_10: hp_m1 = M_G5;
      4'b10_11: hp_m1 = M_C6;
      4'b11_00: hp_m1 = M_G4;
      4'b11_01: hp_m1 = M_E4;
      4'b11_10: hp_m1 = M_C4;
      default:  hp_m1 = M_C4;
    endcase
  end

  always_comb begin
    last_idx = 2'd0;
    case (mel_q)
      MEL_EAT:  last_idx = 2'd1;
      MEL_SUC:  last_idx = 2'd3;
      MEL_FAIL: last_idx = 2'd2;
      default:  last_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mel_d   = mel_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    phase_d = phase_q;
    start   = 1'b0;
    case (state_q)
      IDLE: start = (ev != MEL_NONE);
      PLAY: begin
        if (ev > mel_q) begin
          start = 1'b1;
        end else if (dur_q == DUR_LAST) begin
          // Note boundary: silence and restart the tone from a clean phase.
          dur_d   = '0;
          tone_d  = '0;
          phase_d = 1'b0;
          if (idx_q == last_idx) begin
            state_d = IDLE;
            mel_d   = MEL_NONE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          dur_d = dur_q + DW'(1);
          if (tone_q == hp_m1) begin
            tone_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tone_d = tone_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Entry from IDLE and preemption share the same restart.
    if (start) begin
      state_d = PLAY;
      mel_d   = ev;
      idx_d   = 2'd0;
      dur_d   = '0;
      tone_d  = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 3'b000;
      mel_q   <= MEL_NONE;
      idx_q   <= 2'd0;
      dur_q   <= '0;
      tone_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= {i_failure, i_success, i_eat};
      mel_q   <= mel_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
    end
  end

  assign o_busy = (state_q == PLAY);

`ifdef SFX_MUTE_EN
  // After mute is released the output stays quiet until the tone counter
  // next wraps, so audio resumes on a half-period boundary.
  logic gate_q;
  always_ff @(posedge clk) begin
    if (rst)                gate_q <= 1'b0;
    else if (i_mute)        gate_q <= 1'b1;
    else if (tone_d == '0)  gate_q <= 1'b0;
  end
  assign o_audio = phase_q & ~(i_mute | gate_q);
`else
  assign o_audio = phase_q;
`endif

endmodule

// File: tb/tb_sfx_player.sv
module tb_sfx_player;
  localparam int NL = 1024;
  localparam int TS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_eat = 1'b0, i_success = 1'b0, i_failure = 1'b0, i_mute = 1'b0;
  logic o_audio, o_busy;

  always #5 clk = ~clk;

  sfx_player #(.NOTE_LEN(NL), .TONE_SHIFT(TS)) dut (
    .clk(clk), .rst(rst),
    .i_eat(i_eat), .i_success(i_success), .i_failure(i_failure),
`ifdef SFX_MUTE_EN
    .i_mute(i_mute),
`endif
    .o_audio(o_audio), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a melody is (id, cycles since start); audio is derived
  // from position within the current note.
  int hp_tab [4][4] = '{'{1, 1, 1, 1}, '{18, 15, 1, 1}, '{23, 18, 15, 11}, '{31, 37, 46, 1}};
  int nnotes [4]    = '{0, 2, 4, 3};
  bit m_busy = 0;
  int m_mel = 0;
  int m_t = 0;
  bit p_e = 0, p_s = 0, p_f = 0;

  function automatic logic exp_audio();
    int idx, pos;
    if (!m_busy) return 1'b0;
    idx = m_t / NL;
    pos = m_t % NL;
    return logic'(((pos / hp_tab[m_mel][idx]) % 2) == 1) & ~i_mute;
  endfunction

  task automatic tick();
    int ev;
    @(posedge clk);
    ev = (i_failure && !p_f) ? 3 : (i_success && !p_s) ? 2 : (i_eat && !p_e) ? 1 : 0;
    if (rst) begin
      m_busy = 0; m_mel = 0; m_t = 0; p_e = 0; p_s = 0; p_f = 0;
    end else begin
      p_e = i_eat; p_s = i_success; p_f = i_failure;
      if (m_busy && ev > m_mel) begin
        m_mel = ev; m_t = 0;
      end else if (m_busy) begin
        m_t++;
        if (m_t >= nnotes[m_mel] * NL) begin m_busy = 0; m_mel = 0; m_t = 0; end
      end else if (ev != 0) begin
        m_busy = 1; m_mel = ev; m_t = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; i_eat = 1;
    tick(); tick();
    checks++;
    if (o_busy !== 1'b0 || o_audio !== 1'b0) begin
      errors++; $display("FAIL reset_state busy=%b audio=%b want 0 0", o_busy, o_audio);
    end
    rst = 0;
    tick();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL reset_held_input_starts busy=%b want 1", o_busy);
    end
    i_eat = 0;
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_eat();
    int busy_n = 0, t0, first = -1;
    i_eat = 1; t0 = cyc;
    for (int c = 0; c < 2100; c++) begin
      tick();
      if (c == 0) i_eat = 0;
      if (o_busy === 1'b1) busy_n++;
      if (first < 0 && o_audio === 1'b1) first = cyc - t0;
      checks++;
      if ({o_busy, o_audio} !== {m_busy, exp_audio()}) begin
        errors++; $display("FAIL eat_cycle c=%0d busy/audio=%b%b want %b%b", c, o_busy, o_audio, m_busy, exp_audio());
      end
    end
    checks++;
    if (busy_n != 2048) begin errors++; $display("FAIL eat_busy_len got %0d want 2048", busy_n); end
    checks++;
    if (first != 19) begin errors++; $display("FAIL eat_first_toggle got %0d want 19", first); end
    checks++;
    if (o_audio !== 1'b0) begin errors++; $display("FAIL eat_end_audio got %b want 0", o_audio); end
  endtask

  // Generic two-event scenario: ev_a pulses at start, ev_b pulses after dly.
  task automatic test_two(input string name, input int a, input int b, input int dly,
                          input int n, input int want_busy);
    int busy_n = 0;
    if (a == 1) i_eat = 1; else if (a == 2) i_success = 1; else i_failure = 1;
    if (dly == 0) begin
      if (b == 1) i_eat = 1; else if (b == 2) i_success = 1; else i_failure = 1;
    end
    for (int c = 0; c < n; c++) begin
      tick();
      if (c == 0 || c == dly) begin i_eat = 0; i_success = 0; i_failure = 0; end
      if (dly > 0 && c == dly - 1) begin
        if (b == 1) i_eat = 1; else if (b == 2) i_success = 1; else i_failure = 1;
      end
      if (o_busy === 1'b1) busy_n++;
      checks++;
      if ({o_busy, o_audio} !== {m_busy, exp_audio()}) begin
        errors++; $display("FAIL %s_cycle c=%0d busy/audio=%b%b want %b%b", name, c, o_busy, o_audio, m_busy, exp_audio());
      end
    end
    checks++;
    if (busy_n != want_busy) begin
      errors++; $display("FAIL %s_busy_len got %0d want %0d", name, busy_n, want_busy);
    end
  endtask

  task automatic test_reset_mid();
    i_eat = 1;
    for (int c = 0; c < 703; c++) begin
      tick();
      if (c == 0) i_eat = 0;
    end
    checks++;
    if (o_audio !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset busy/audio=%b%b want 11", o_busy, o_audio);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if (o_audio !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset busy/audio=%b%b want 00", o_busy, o_audio);
    end
    tick();
  endtask

  task automatic test_held();
    int busy_n = 0;
    i_eat = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (o_busy === 1'b1) busy_n++;
    end
    checks++;
    if (busy_n != 2048) begin errors++; $display("FAIL held_no_retrigger got %0d want 2048", busy_n); end
    i_eat = 0; tick();
  endtask

`ifdef SFX_MUTE_EN
  task automatic test_mute();
    int busy_n = 0, hi = 0;
    i_mute = 1; i_success = 1;
    for (int c = 0; c < 4200; c++) begin
      tick();
      if (c == 0) i_success = 0;
      if (o_busy === 1'b1) busy_n++;
      if (o_audio !== 1'b0) hi++;
    end
    checks++;
    if (busy_n != 4096) begin errors++; $display("FAIL mute_busy_len got %0d want 4096", busy_n); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL mute_audio_high got %0d want 0", hi); end
    i_mute = 0; tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 499) == 0) i_eat = $urandom_range(0, 1);
      if ($urandom_range(0, 699) == 0) i_success = $urandom_range(0, 1);
      if ($urandom_range(0, 999) == 0) i_failure = $urandom_range(0, 1);
      rst = ($urandom_range(0, 7999) == 0);
      tick();
      checks++;
      if ({o_busy, o_audio} !== {m_busy, exp_audio()}) begin
        errors++; $display("FAIL random_cycle c=%0d busy/audio=%b%b want %b%b", c, o_busy, o_audio, m_busy, exp_audio());
      end
    end
    rst = 0; i_eat = 0; i_success = 0; i_failure = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_eat();
    test_two("preempt", 2, 3, 300, 3500, 3372);
    test_two("drop", 2, 1, 500, 4200, 4096);
    test_two("simul", 1, 3, 0, 3200, 3072);
    test_reset_mid();
    test_held();
`ifdef SFX_MUTE_EN
    test_mute();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
